// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU.
//   Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on XLEN-bit
//   operands. A normal op is accepted in IDLE, then runs XLEN CALC cycles
//   (shift-add multiply or restoring divide on operand magnitudes), one FIX
//   cycle (sign correction and half/quotient/remainder select), and waits in
//   DONE until the consumer takes the result. Divide-by-zero and signed
//   overflow skip CALC/FIX and go straight to DONE.
//
// Ports
//   clock      in   1           rising-edge clock
//   reset      in   1           synchronous, active-high
//   in_valid   in   1           op request
//   in_ready   out  1           unit can accept (IDLE)
//   Funct3     in   3           RV32M op select
//   op_a       in   XLEN        rs1 value
//   op_b       in   XLEN        rs2 value
//   in_rd      in   REG_ADDR_W  destination tag
//   flush      in   1           abort in-flight op, back to IDLE
//   out_valid  out  1           result available (DONE)
//   out_ready  in   1           consumer takes result
//   result     out  XLEN        product high/low half, quotient or remainder
//   out_rd     out  REG_ADDR_W  tag of result
//   busy       out  1           state != IDLE, stalls the core
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            Funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nx;
    logic [2:0]          fn;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [2*XLEN-1:0]   acc;
    logic                neg;
    logic [CW-1:0]       count;

    // ---------------- issue-side decode (only meaningful when accepting) -----
    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg, sign_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_val;

    // flush beats in_valid: a flushed request is never taken.
    assign accept   = in_valid && in_ready && !flush;

    assign a_signed = (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                      (Funct3 == F_DIV)  || (Funct3 == F_REM);
    assign b_signed = (Funct3 == F_MULH) || (Funct3 == F_DIV) || (Funct3 == F_REM);
    assign a_neg    = a_signed && op_a[XLEN-1];
    assign b_neg    = b_signed && op_b[XLEN-1];
    // MIN negates to itself, which is exactly its magnitude read as unsigned.
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    // Remainder takes the dividend's sign; everything else takes a^b.
    assign sign_in  = (Funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = Funct3[2] && (op_b == '0);
    assign overflow = ((Funct3 == F_DIV) || (Funct3 == F_REM)) &&
                      (op_a == MIN_VAL) && (op_b == '1);
    assign special  = div_zero || overflow;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        special_val = '0;
        if (div_zero)
            special_val = Funct3[1] ? op_a : '1;
        else if (overflow)
            special_val = Funct3[1] ? '0 : MIN_VAL;
    end

    // ---------------- one iteration of multiply / divide ---------------------
    // Multiply: acc = {partial product, remaining multiplier bits}; add a_abs
    // into the upper half when the LSB is set, then shift right one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nx;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_abs} : '0);
    assign mul_nx  = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}. Shift left one;
    // the shifted-out remainder MSB means the trial value already exceeds the
    // divisor, so the X-bit difference is exact and no wider adder is needed.
    logic            div_top, div_ge;
    logic [XLEN-1:0] div_low, div_rem;
    logic [2*XLEN-1:0] div_nx;
    assign div_top = acc[2*XLEN-1];
    assign div_low = acc[2*XLEN-2:XLEN-1];
    assign div_ge  = div_top || (div_low >= b_abs);
    assign div_rem = div_ge ? (div_low - b_abs) : div_low;
    assign div_nx  = {div_rem, acc[XLEN-2:0], div_ge};

    // ---------------- FIX-stage sign correction and select -------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;
    assign prod_fix = neg ? -acc : acc;
    assign quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = '0;
        if (fn[2])
            fix_val = fn[1] ? rem_fix : quo_fix;
        else if (fn == F_MUL)
            fix_val = prod_fix[XLEN-1:0];
        else
            fix_val = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- FSM next state ------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)          state_nx = special ? DONE : CALC;
            CALC: if (count == '0)     state_nx = FIX;
            FIX:                       state_nx = DONE;
            DONE: if (out_ready)       state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // ---------------- state and datapath registers ----------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the operand/accumulator registers are reset too; they are
            // few and a known value keeps the post-reset datapath deterministic.
            state  <= IDLE;
            fn     <= '0;
            a_abs  <= '0;
            b_abs  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            count  <= '0;
            result <= '0;
            out_rd <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        fn     <= Funct3;
                        out_rd <= in_rd;
                        if (special) begin
                            result <= special_val;
                        end else begin
                            a_abs <= a_mag;
                            b_abs <= b_mag;
                            neg   <= sign_in;
                            count <= CW'(XLEN - 1);
                            acc   <= Funct3[2] ? {{XLEN{1'b0}}, a_mag}
                                               : {{XLEN{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    acc   <= fn[2] ? div_nx : mul_nx;
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (!flush)
                        result <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit (XLEN=32). Expected values are
//   hand-computed RV32M results; latency is counted in clock edges from the
//   accept edge (inclusive) to the first cycle with out_valid high.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int LAT  = XLEN + 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic [RW-1:0]   in_rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   out_rd;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Funct3    (Funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_rd    (out_rd),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; it is accepted on the next posedge.
    task automatic send(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
        @(negedge clock);
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        Funct3   = f;
        op_a     = a;
        op_b     = b;
        in_rd    = rd;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        // Garbage on the operand bus must not disturb the running op.
        Funct3   = 3'b111;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0000_0000;
        in_rd    = 5'd31;
    endtask

    // Count edges until out_valid, then check latency, result and tag.
    task automatic wait_result(input string tag, input logic [31:0] exp,
                               input logic [4:0] rd, input int exp_lat);
        int lat = 1;
        forever begin
            @(negedge clock);
            if (out_valid || lat > 200) break;
            @(posedge clock);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp);
        check({tag, " out_rd"}, out_rd, rd);
    endtask

    task automatic release_result(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check({tag, " out_valid clear"}, out_valid, 0);
        check({tag, " idle"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        send(tag, f, a, b, rd);
        wait_result(tag, exp, rd, exp_lat);
        release_result(tag);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        Funct3    = '0;
        op_a      = '0;
        op_b      = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst out_valid", out_valid, 0);
        check("rst result",    result,    0);
        check("rst out_rd",    out_rd,    0);
        check("rst busy",      busy,      0);
        check("rst in_ready",  in_ready,  1);

        // Multiplies
        run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, LAT);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, LAT);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, LAT);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, LAT);

        // Divides
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, LAT);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, LAT);
        run_op("divu",   3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        LAT);
        run_op("remu",   3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         LAT);
        run_op("div_negb", 3'b100, 32'd20,      32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA, LAT);
        run_op("rem_negb", 3'b110, 32'd20,      32'hFFFF_FFFD, 5'd12, 32'd2,         LAT);

        // Special cases, one-cycle latency
        run_op("divu_by0", 3'b101, 32'd5,        32'd0,         5'd13, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",  3'b110, 32'd5,        32'd0,         5'd14, 32'd5,         1);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,        1);

        // Back-pressure: hold DONE with out_ready low and a competing request
        send("hold", 3'b101, 32'd100, 32'd7, 5'd17);
        wait_result("hold", 32'd14, 5'd17, LAT);
        in_valid = 1'b1;
        Funct3   = 3'b000;
        op_a     = 32'd3;
        op_b     = 32'd3;
        in_rd    = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold out_valid", out_valid, 1);
            check("hold result",    result,    32'd14);
            check("hold out_rd",    out_rd,    5'd17);
            check("hold in_ready",  in_ready,  0);
        end
        in_valid = 1'b0;
        release_result("hold");
        @(negedge clock);
        check("hold no stray accept", busy, 0);

        // Reset at CALC cycle 10
        send("rstcalc", 3'b000, 32'd6, 32'd7, 5'd18);
        repeat (9) @(posedge clock);
        @(negedge clock);
        check("rstcalc busy before", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rstcalc out_valid", out_valid, 0);
        check("rstcalc busy",      busy,      0);
        check("rstcalc result",    result,    0);
        run_op("after_rst", 3'b000, 32'd6, 32'd7, 5'd19, 32'd42, LAT);

        // Flush at CALC cycle 10
        send("flushcalc", 3'b101, 32'd1000, 32'd3, 5'd20);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flushcalc out_valid", out_valid, 0);
        check("flushcalc busy",      busy,      0);
        run_op("after_flush", 3'b111, 32'd1000, 32'd3, 5'd21, 32'd1, LAT);

        // Flush together with in_valid in IDLE: request must be dropped
        @(negedge clock);
        in_valid = 1'b1;
        flush    = 1'b1;
        Funct3   = 3'b101;
        op_a     = 32'd9;
        op_b     = 32'd0;
        in_rd    = 5'd22;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clock);
        check("flush_idle busy",      busy,      0);
        check("flush_idle out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
